// File: rtl/ysyx_25040109_lsu_axi_master_pkg.sv
// Shared types for the LSU AXI-lite initiator: access size codes, bus response
// code, FSM states and the alignment rule used by the optional misalign trap
// (YSYX_25040109_LSU_MISALIGN_TRAP_EN).
package ysyx_25040109_lsu_axi_master_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3   // illegal encoding, handled as a word
  } lsu_size_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } lsu_state_e;

  // True when the low address bits violate the natural alignment of the size.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040109_lsu_axi_master_if.sv
// AXI-lite style single-port memory bus (AR/R/AW/W/B) between the LSU
// initiator and the arbiter/memory side.
interface ysyx_25040109_lsu_axi_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25040109_lsu_axi_master_align.sv
// Combinational byte-lane steering for the LSU: write strobes, replicated
// store data, and load data shifted, truncated and sign/zero extended.
// Low address bits below the size alignment are ignored (half uses a[1],
// word uses lane 0).
module ysyx_25040109_lsu_axi_master_align
  import ysyx_25040109_lsu_axi_master_pkg::*;
(
  input  logic [1:0]  i_off,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_lane;
  logic [31:0] w_shifted;

  // Pick the size-aligned lane, the strobe pattern and replicated store data
  always_comb begin
    w_lane  = 2'b00;
    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    case (i_size)
      SIZE_B: begin
        w_lane  = i_off;
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_H: begin
        w_lane  = {i_off[1], 1'b0};
        o_wstrb = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shifted = i_rdata >> {w_lane, 3'b000};

  // Truncate the shifted read word to the access size and extend it
  always_comb begin
    o_rdata = w_shifted;
    case (i_size)
      SIZE_B: o_rdata = i_unsigned ? {24'h0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SIZE_H: o_rdata = i_unsigned ? {16'h0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25040109_lsu_axi_master.sv
// LSU AXI-lite initiator: one blocking load (AR/R) or store (AW/W/B) per CPU
// request, registered bus outputs, result held until the CPU accepts it.
// Optional YSYX_25040109_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// skip the bus and answer with resp_err the cycle after accept.
module ysyx_25040109_lsu_axi_master
  import ysyx_25040109_lsu_axi_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  ysyx_25040109_lsu_axi_master_if.master mem
);

  lsu_state_e          r_state;
  logic [1:0]          r_off;
  lsu_size_e           r_size;
  logic                r_uns;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_rready;
  logic                r_awvalid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_wvalid;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_bready;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;

  lsu_size_e           w_req_size;
  logic [1:0]          w_al_off;
  lsu_size_e           w_al_size;
  logic [3:0]          w_wstrb;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata_ext;
  logic                w_aw_done;
  logic                w_w_done;

  assign w_req_size = lsu_size_e'(req_size);

  // One aligner serves both directions: in IDLE it sees the incoming store,
  // afterwards the latched request that the read data belongs to.
  assign w_al_off  = (r_state == ST_IDLE) ? req_addr[1:0] : r_off;
  assign w_al_size = (r_state == ST_IDLE) ? w_req_size    : r_size;

  ysyx_25040109_lsu_axi_master_align u_align (
    .i_off      (w_al_off),
    .i_size     (w_al_size),
    .i_unsigned (r_uns),
    .i_wdata    (req_wdata),
    .i_rdata    (mem.rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata_ext)
  );

  assign w_aw_done = r_aw_done | (r_awvalid & mem.awready);
  assign w_w_done  = r_w_done  | (r_wvalid  & mem.wready);

  // Transaction FSM with registered bus and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_off        <= '0;
      r_size       <= SIZE_B;
      r_uns        <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_awaddr     <= '0;
      r_wvalid     <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_off  <= req_addr[1:0];
            r_size <= w_req_size;
            r_uns  <= req_unsigned;
`ifdef YSYX_25040109_LSU_MISALIGN_TRAP_EN
            if (is_misaligned(w_req_size, req_addr[1:0])) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= ST_RESP;
            end else
`endif
            if (req_wen) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              r_wdata   <= w_wdata;
              r_wstrb   <= w_wstrb;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              r_state   <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (mem.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (mem.rvalid) begin
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_rdata_ext;
            r_resp_err   <= (mem.rresp != RESP_OKAY);
            r_state      <= ST_RESP;
          end
        end
        ST_WR: begin
          // AW and W complete independently; B waits for both.
          if (r_awvalid && mem.awready) r_awvalid <= 1'b0;
          if (r_wvalid && mem.wready)   r_wvalid  <= 1'b0;
          r_aw_done <= w_aw_done;
          r_w_done  <= w_w_done;
          if (w_aw_done && w_w_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_B;
          end
        end
        ST_B: begin
          if (mem.bvalid) begin
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_err   <= (mem.bresp != RESP_OKAY);
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;

  assign mem.arvalid = r_arvalid;
  assign mem.araddr  = r_araddr;
  assign mem.rready  = r_rready;
  assign mem.awvalid = r_awvalid;
  assign mem.awaddr  = r_awaddr;
  assign mem.wvalid  = r_wvalid;
  assign mem.wdata   = r_wdata;
  assign mem.wstrb   = r_wstrb;
  assign mem.bready  = r_bready;

endmodule

// File: tb/tb_ysyx_25040109_lsu_axi_master.sv
// Self-checking bench for ysyx_25040109_lsu_axi_master: directed vector table,
// randomized transactions against a behavioural model, and an async reset
// abort sequence. Honours YSYX_25040109_LSU_MISALIGN_TRAP_EN for expectations.
module tb_ysyx_25040109_lsu_axi_master;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] word;
    logic [1:0]  resp;
    int unsigned ar_lat, r_lat, aw_lat, w_lat, b_lat, hold;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    int unsigned e_lat;
    logic        e_bus;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  ysyx_25040109_lsu_axi_master_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  ysyx_25040109_lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem          (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // slave configuration and observations
  int unsigned s_ar_lat, s_r_lat, s_aw_lat, s_w_lat, s_b_lat;
  logic [31:0] s_rword;
  logic [1:0]  s_rresp, s_bresp;
  int unsigned ar_hs, aw_hs, w_hs, drop_err, stable_err;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory-side responder with programmable wait states.
  initial begin
    int unsigned ar_c, r_c, aw_c, w_c, b_c;
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] f_awaddr, f_wdata;
    logic [3:0]  f_wstrb;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    f_awaddr = '0; f_wdata = '0; f_wstrb = '0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; drop_err = 0; stable_err = 0;
    cap_araddr = '0; cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
    mem_if.arready = 0; mem_if.rvalid = 0; mem_if.rdata = '0; mem_if.rresp = '0;
    mem_if.awready = 0; mem_if.wready = 0; mem_if.bvalid = 0; mem_if.bresp = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        mem_if.arready = 0; mem_if.rvalid = 0; mem_if.awready = 0;
        mem_if.wready = 0; mem_if.bvalid = 0;
      end else begin
        if (p_arv && !p_arr && !mem_if.arvalid) drop_err++;
        if (p_awv && !p_awr && !mem_if.awvalid) drop_err++;
        if (p_wv && !p_wr && !mem_if.wvalid) drop_err++;
        if (mem_if.arvalid) begin
          mem_if.arready = (ar_c >= s_ar_lat);
          if (mem_if.arready) begin ar_hs++; cap_araddr = mem_if.araddr; end
          ar_c++;
        end else begin mem_if.arready = 0; ar_c = 0; end
        if (mem_if.rready) begin
          mem_if.rvalid = (r_c >= s_r_lat);
          mem_if.rdata  = mem_if.rvalid ? s_rword : $urandom;
          mem_if.rresp  = mem_if.rvalid ? s_rresp : 2'b00;
          r_c++;
        end else begin mem_if.rvalid = 0; r_c = 0; end
        if (mem_if.awvalid) begin
          if (aw_c == 0) f_awaddr = mem_if.awaddr;
          else if (mem_if.awaddr !== f_awaddr) stable_err++;
          mem_if.awready = (aw_c >= s_aw_lat);
          if (mem_if.awready) begin aw_hs++; cap_awaddr = mem_if.awaddr; end
          aw_c++;
        end else begin mem_if.awready = 0; aw_c = 0; end
        if (mem_if.wvalid) begin
          if (w_c == 0) begin f_wdata = mem_if.wdata; f_wstrb = mem_if.wstrb; end
          else if (mem_if.wdata !== f_wdata || mem_if.wstrb !== f_wstrb) stable_err++;
          mem_if.wready = (w_c >= s_w_lat);
          if (mem_if.wready) begin w_hs++; cap_wdata = mem_if.wdata; cap_wstrb = mem_if.wstrb; end
          w_c++;
        end else begin mem_if.wready = 0; w_c = 0; end
        if (mem_if.bready) begin
          mem_if.bvalid = (b_c >= s_b_lat);
          mem_if.bresp  = s_bresp;
          b_c++;
        end else begin mem_if.bvalid = 0; b_c = 0; end
        p_arv = mem_if.arvalid; p_arr = mem_if.arready;
        p_awv = mem_if.awvalid; p_awr = mem_if.awready;
        p_wv  = mem_if.wvalid;  p_wr  = mem_if.wready;
      end
    end
  end

  // Behavioural reference: expected result from size/alignment arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int unsigned nb, off, idx, mx;
    longint      x;
    r = v;
    nb  = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    off = v.addr % 4;
    idx = off - (off % nb);
    r.e_addr = v.addr - off;
    r.e_bus = 1'b1;
    r.e_strb = '0;
    r.e_wdata = '0;
`ifdef YSYX_25040109_LSU_MISALIGN_TRAP_EN
    if ((off % nb) != 0) begin
      r.e_bus = 1'b0; r.e_err = 1'b1; r.e_rdata = '0; r.e_lat = 1;
      return r;
    end
`endif
    r.e_err = (v.resp != 2'b00);
    if (v.wen) begin
      r.e_rdata = '0;
      r.e_strb = 4'(((1 << nb) - 1) << idx);
      for (int k = 0; k < 4; k++)
        r.e_wdata = r.e_wdata | (((v.wdata >> (8 * (k % nb))) & 32'hFF) << (8 * k));
      mx = (v.aw_lat > v.w_lat) ? v.aw_lat : v.w_lat;
      r.e_lat = 3 + mx + v.b_lat;
    end else begin
      x = longint'(v.word >> (8 * idx));
      if (nb < 4) begin
        x = x % (longint'(1) << (8 * nb));
        if (!v.uns && x >= (longint'(1) << (8 * nb - 1))) x = x - (longint'(1) << (8 * nb));
      end
      r.e_rdata = x[31:0];
      r.e_lat = 3 + v.ar_lat + v.r_lat;
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, wdata,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] word, input logic [1:0] resp,
                              input int unsigned arl, rl, awl, wl, bl, hold,
                              input logic [31:0] e_rdata, input logic e_err,
                              input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic [31:0] e_wdata, input int unsigned e_lat,
                              input logic e_bus);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.word = word; v.resp = resp; v.ar_lat = arl; v.r_lat = rl; v.aw_lat = awl;
    v.w_lat = wl; v.b_lat = bl; v.hold = hold; v.e_rdata = e_rdata; v.e_err = e_err;
    v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_lat = e_lat;
    v.e_bus = e_bus;
    return v;
  endfunction

  // Drive one request through the DUT and compare everything observed.
  task automatic run_and_check(input string tag, input vec_t v);
    int unsigned lat, ar0, aw0, w0, order_err, hold_err;
    logic        ready_ok, bus_seen, post_ok, err;
    logic [31:0] rdata;
    s_ar_lat = v.ar_lat; s_r_lat = v.r_lat; s_aw_lat = v.aw_lat;
    s_w_lat = v.w_lat; s_b_lat = v.b_lat; s_rword = v.word;
    s_rresp = v.wen ? 2'b00 : v.resp; s_bresp = v.wen ? v.resp : 2'b00;
    @(negedge clk);
    ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
    ready_ok = req_ready;
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0; order_err = 0; bus_seen = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (mem_if.arvalid || mem_if.awvalid || mem_if.wvalid) bus_seen = 1'b1;
      if (mem_if.bready && (mem_if.awvalid || mem_if.wvalid)) order_err++;
      if (resp_valid) break;
      // request-side changes while busy must be ignored
      req_valid = 1'($urandom); req_wen = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_size = 2'($urandom); req_unsigned = 1'($urandom);
    end
    req_valid = 1'b0;
    rdata = resp_rdata; err = resp_err;
    hold_err = 0;
    for (int unsigned i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (!resp_valid || req_ready || resp_rdata !== rdata || resp_err !== err) hold_err++;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    post_ok = !resp_valid && req_ready;
    chk({tag, ".req_ready_idle"}, 32'(ready_ok), 32'd1);
    chk({tag, ".latency"}, lat, v.e_lat);
    chk({tag, ".resp_err"}, 32'(err), 32'(v.e_err));
    chk({tag, ".resp_rdata"}, rdata, v.e_rdata);
    chk({tag, ".bus_activity"}, 32'(bus_seen), 32'(v.e_bus));
    if (v.e_bus && !v.wen) begin
      chk({tag, ".ar_count"}, ar_hs - ar0, 32'd1);
      chk({tag, ".araddr"}, cap_araddr, v.e_addr);
    end else if (v.e_bus) begin
      chk({tag, ".aw_w_count"}, (aw_hs - aw0) + (w_hs - w0), 32'd2);
      chk({tag, ".awaddr"}, cap_awaddr, v.e_addr);
      chk({tag, ".wstrb"}, 32'(cap_wstrb), 32'(v.e_strb));
      chk({tag, ".wdata"}, cap_wdata, v.e_wdata);
      chk({tag, ".b_after_aw_w"}, order_err, 32'd0);
    end else begin
      chk({tag, ".no_handshakes"}, (ar_hs - ar0) + (aw_hs - aw0) + (w_hs - w0), 32'd0);
    end
    chk({tag, ".resp_hold"}, hold_err, 32'd0);
    chk({tag, ".after_handshake"}, 32'(post_ok), 32'd1);
  endtask

  vec_t tbl[13];

  initial begin
    vec_t v;
    rst = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    s_ar_lat = 0; s_r_lat = 0; s_aw_lat = 0; s_w_lat = 0; s_b_lat = 0;
    s_rword = '0; s_rresp = '0; s_bresp = '0;

    //      wen addr          wdata         sz uns word          rsp ar r aw w b hold e_rdata       err e_addr        strb     e_wdata       lat bus
    tbl[0]  = mk(0, 32'h8000_0004, 32'h0,         2, 0, 32'hDEAD_BEEF, 0, 0,0,0,0,0, 0, 32'hDEAD_BEEF, 0, 32'h8000_0004, 4'h0, 32'h0,         3, 1);
    tbl[1]  = mk(0, 32'h8000_0003, 32'h0,         0, 0, 32'h80FF_0000, 0, 0,0,0,0,0, 1, 32'hFFFF_FF80, 0, 32'h8000_0000, 4'h0, 32'h0,         3, 1);
    tbl[2]  = mk(0, 32'h8000_0003, 32'h0,         0, 1, 32'h80FF_0000, 0, 2,1,0,0,0, 0, 32'h0000_0080, 0, 32'h8000_0000, 4'h0, 32'h0,         6, 1);
    tbl[3]  = mk(1, 32'h8000_0002, 32'h1234_ABCD, 1, 0, 32'h0,         0, 0,0,0,3,0, 0, 32'h0,         0, 32'h8000_0000, 4'hC, 32'hABCD_ABCD, 6, 1);
    tbl[4]  = mk(1, 32'h8000_0010, 32'h1122_3344, 2, 0, 32'h0,         2, 0,0,0,0,0, 5, 32'h0,         1, 32'h8000_0010, 4'hF, 32'h1122_3344, 3, 1);
`ifdef YSYX_25040109_LSU_MISALIGN_TRAP_EN
    tbl[5]  = mk(0, 32'h8000_0001, 32'h0,         2, 0, 32'hCAFE_F00D, 0, 0,0,0,0,0, 0, 32'h0,         1, 32'h8000_0000, 4'h0, 32'h0,         1, 0);
    tbl[12] = mk(1, 32'h8000_0003, 32'h0000_BEEF, 1, 0, 32'h0,         0, 0,0,0,0,0, 2, 32'h0,         1, 32'h8000_0000, 4'h0, 32'h0,         1, 0);
`else
    tbl[5]  = mk(0, 32'h8000_0001, 32'h0,         2, 0, 32'hCAFE_F00D, 0, 0,0,0,0,0, 0, 32'hCAFE_F00D, 0, 32'h8000_0000, 4'h0, 32'h0,         3, 1);
    tbl[12] = mk(1, 32'h8000_0003, 32'h0000_BEEF, 1, 0, 32'h0,         0, 0,0,0,0,0, 2, 32'h0,         0, 32'h8000_0000, 4'hC, 32'hBEEF_BEEF, 3, 1);
`endif
    tbl[6]  = mk(0, 32'h8000_0006, 32'h0,         1, 0, 32'h8001_7FFF, 0, 0,2,0,0,0, 0, 32'hFFFF_8001, 0, 32'h8000_0004, 4'h0, 32'h0,         5, 1);
    tbl[7]  = mk(0, 32'h8000_0002, 32'h0,         1, 1, 32'h8001_7FFF, 0, 0,0,0,0,0, 0, 32'h0000_8001, 0, 32'h8000_0000, 4'h0, 32'h0,         3, 1);
    tbl[8]  = mk(1, 32'h8000_0001, 32'h0000_00A5, 0, 0, 32'h0,         0, 0,0,3,0,2, 0, 32'h0,         0, 32'h8000_0000, 4'h2, 32'hA5A5_A5A5, 8, 1);
    tbl[9]  = mk(0, 32'h8000_0008, 32'h0,         2, 0, 32'h1234_5678, 3, 1,0,0,0,0, 0, 32'h1234_5678, 1, 32'h8000_0008, 4'h0, 32'h0,         4, 1);
    tbl[10] = mk(0, 32'h8000_000C, 32'h0,         3, 0, 32'h89AB_CDEF, 0, 0,0,0,0,0, 0, 32'h89AB_CDEF, 0, 32'h8000_000C, 4'h0, 32'h0,         3, 1);
    tbl[11] = mk(0, 32'h8000_0001, 32'h0,         0, 0, 32'h0000_7F00, 0, 0,0,0,0,0, 0, 32'h0000_007F, 0, 32'h8000_0000, 4'h0, 32'h0,         3, 1);

    // reset state
    #2;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.resp_valid", 32'(resp_valid), 32'd0);
    chk("reset.resp_err", 32'(resp_err), 32'd0);
    chk("reset.resp_rdata", resp_rdata, 32'd0);
    chk("reset.bus_valids", 32'({mem_if.arvalid, mem_if.awvalid, mem_if.wvalid}), 32'd0);
    chk("reset.bus_readies", 32'({mem_if.rready, mem_if.bready}), 32'd0);
    chk("reset.bus_addr_data", mem_if.araddr | mem_if.awaddr | mem_if.wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 13; i++) run_and_check($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v = mk(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), $urandom,
             2'($urandom_range(0, 3) == 0 ? $urandom : 0),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             '0, 1'b0, '0, '0, '0, 0, 1'b0);
      run_and_check($sformatf("rnd%0d", i), model(v));
    end

    // async reset while AR is stalled
    s_ar_lat = 1000;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0020; req_size = 2'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort.arvalid_before", 32'(mem_if.arvalid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort.arvalid_in_reset", 32'(mem_if.arvalid), 32'd0);
    chk("abort.resp_valid_in_reset", 32'(resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort.req_ready_after", 32'(req_ready), 32'd1);
    chk("abort.arvalid_after", 32'(mem_if.arvalid), 32'd0);
    run_and_check("post_abort", tbl[0]);

    chk("bus.valid_drop", drop_err, 32'd0);
    chk("bus.aw_w_stable", stable_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
